shift_sequencer: RTL and testbench

Multi-cycle controller that sequences an 8-bit shift/rotate operation as repeated single-bit shift steps on an internal 1-bit shift datapath.
- Accepts one request at a time through a START/READY handshake.
- Reports completion with a one-cycle DONE pulse; RESULT holds until the next completion.
- Sits beside the ALU and serves shift instructions whose amount exceeds the combinational shifter's range, or rotate ops.

---
 rtl/shift_sequencer.sv | 140 ++++++++++++++
 tb/tb_shift_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shift/rotate sequencer built on a single-bit step datapath.
// Optional build macro SHIFT_SEQ_DOUBLE_STEP_EN applies two steps per SHIFT edge.
module shift_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [WIDTH-1:0] AMOUNT,
    input  logic [1:0]       OP,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Latched request; fields are only written on an accepted START.
    typedef struct packed {
        op_e             op;
        logic [WIDTH-1:0] work;
    } req_t;

    state_e           state, state_next;
    req_t             req;
    logic [3:0]       count;
    logic [3:0]       eff_count;
    logic [3:0]       dec;
    logic [WIDTH-1:0] work_next;
    logic             load;
    logic             advance;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w, input op_e op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_LSL:  r = {w[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {1'b0, w[WIDTH-1:1]};
            OP_ASR:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            default: r = {w[0], w[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Shifts saturate at the width; rotates wrap modulo the width.
    always_comb begin
        eff_count = 4'd0;
        if (op_e'(OP) == OP_ROR)
            eff_count = {1'b0, AMOUNT[2:0]};
        else if (AMOUNT >= WIDTH[WIDTH-1:0])
            eff_count = 4'(WIDTH);
        else
            eff_count = AMOUNT[3:0];
    end

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    always_comb begin
        work_next = step(req.work, req.op);
        dec       = 4'd1;
        if (count >= 4'd2) begin
            work_next = step(step(req.work, req.op), req.op);
            dec       = 4'd2;
        end
    end
`else
    always_comb begin
        work_next = step(req.work, req.op);
        dec       = 4'd1;
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        READY      = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: begin
                READY = 1'b1;
                if (START) begin
                    load       = 1'b1;
                    state_next = (eff_count == 4'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                BUSY    = 1'b1;
                advance = 1'b1;
                if (count <= dec)
                    state_next = S_DONE;
            end
            S_DONE: begin
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req    <= '0;
            count  <= '0;
            RESULT <= '0;
        end else if (load) begin
            req.work <= DATA_IN;
            req.op   <= op_e'(OP);
            count    <= eff_count;
            if (eff_count == 4'd0)
                RESULT <= DATA_IN;
        end else if (advance) begin
            req.work <= work_next;
            count    <= count - dec;
            // Final step lands straight in RESULT so it is valid with DONE.
            if (count <= dec)
                RESULT <= work_next;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] DATA_IN;
    logic [7:0] AMOUNT;
    logic [1:0] OP;
    logic       READY;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    int         total = 0;
    int         bad = 0;
    logic [7:0] last_result = 8'h00;

    shift_sequencer #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA_IN(DATA_IN),
        .AMOUNT(AMOUNT), .OP(OP), .READY(READY), .BUSY(BUSY),
        .DONE(DONE), .RESULT(RESULT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_n(input logic [7:0] a, input logic [1:0] op);
        if (op == 2'b11) return int'(a) % 8;
        return (a > 8'd8) ? 8 : int'(a);
    endfunction

    function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [7:0] a, input logic [1:0] op);
        int n;
        logic [15:0] wide;
        n = ref_n(a, op);
        case (op)
            2'b00: begin wide = 16'(d) << n; return wide[7:0]; end
            2'b01: return d >> n;
            2'b10: return 8'($signed(d) >>> n);
            default: begin wide = {d, d} >> n; return wide[7:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [7:0] a, input logic [1:0] op);
        int n;
        n = ref_n(a, op);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Called just after the accepting edge; latency 1 means DONE in the next cycle.
    task automatic wait_done(input logic [7:0] exp, input int explat, input bit noise, input bit held);
        int lat;
        bit seen;
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            chk("onehot", 32'($countones({READY, BUSY, DONE})), 32'd1);
            if (DONE) begin
                seen = 1'b1;
                if (!held) START = 1'b0;
                break;
            end
            chk("result_hold", RESULT, last_result);
            if (!held && START) START = 1'b0;
            else if (noise && BUSY && $urandom_range(0, 2) == 0) begin
                START = 1'b1;
                DATA_IN = 8'($urandom);
                AMOUNT = 8'($urandom);
                OP = 2'($urandom);
            end
            lat++;
        end
        chk("done_seen", seen, 1);
        chk("result", RESULT, exp);
        chk("latency", lat, explat);
        last_result = exp;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge CLK);
        while (!READY && g < 20) begin
            @(negedge CLK);
            g++;
        end
        chk("ready_wait", READY, 1);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [7:0] a, input logic [1:0] op, input bit noise);
        wait_ready();
        DATA_IN = d;
        AMOUNT = a;
        OP = op;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (noise) begin
            DATA_IN = 8'($urandom);
            AMOUNT = 8'($urandom);
            OP = 2'($urandom);
        end
        wait_done(ref_res(d, a, op), ref_lat(a, op), noise, 1'b0);
        @(negedge CLK);
        chk("done_pulse", DONE, 0);
        chk("ready_after", READY, 1);
        chk("result_stable", RESULT, last_result);
    endtask

    initial begin
        bit any_done;
        RESET = 1'b0;
        START = 1'b0;
        DATA_IN = 8'h00;
        AMOUNT = 8'h00;
        OP = 2'b00;
        repeat (2) @(negedge CLK);
        chk("rst_ready", READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 8'h00);
        RESET = 1'b1;

        run_op(8'h15, 8'd3, 2'b00, 1'b0);
        run_op(8'h80, 8'd3, 2'b10, 1'b0);
        run_op(8'hFF, 8'd3, 2'b10, 1'b0);
        run_op(8'h7F, 8'd200, 2'b10, 1'b0);
        run_op(8'h81, 8'd9, 2'b11, 1'b0);
        run_op(8'h81, 8'd8, 2'b11, 1'b0);
        run_op(8'h7F, 8'd200, 2'b01, 1'b0);
        run_op(8'hC3, 8'd0, 2'b00, 1'b0);

        // Mid-op START pulses with new operands must be ignored.
        run_op(8'h5A, 8'd6, 2'b00, 1'b1);

        // START held high across two operations.
        wait_ready();
        DATA_IN = 8'h96;
        AMOUNT = 8'd2;
        OP = 2'b01;
        START = 1'b1;
        @(posedge CLK);
        #1;
        wait_done(ref_res(8'h96, 8'd2, 2'b01), ref_lat(8'd2, 2'b01), 1'b0, 1'b1);
        DATA_IN = 8'h3C;
        AMOUNT = 8'd5;
        OP = 2'b11;
        @(negedge CLK);
        chk("held_idle", READY, 1);
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(ref_res(8'h3C, 8'd5, 2'b11), ref_lat(8'd5, 2'b11), 1'b0, 1'b0);

        // Reset asserted mid-operation drops the op without DONE.
        wait_ready();
        DATA_IN = 8'h7F;
        AMOUNT = 8'd200;
        OP = 2'b01;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mid_rst_ready", READY, 1);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_result", RESULT, 8'h00);
        @(negedge CLK);
        RESET = 1'b1;
        last_result = 8'h00;
        any_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (DONE) any_done = 1'b1;
        end
        chk("no_done_after_abort", any_done, 0);
        chk("idle_after_abort", READY, 1);
        chk("result_after_abort", RESULT, 8'h00);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            run_op(8'($urandom), a, 2'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
